// File: rtl/corevx_cache_arbiter_pkg.sv
// corevx_cache_arbiter_pkg: shared cache command/response codes and arbiter port identifiers
package corevx_cache_arbiter_pkg;
  localparam logic [3:0] CACHE_CMD_NONE  = 4'd0;
  localparam logic [3:0] CACHE_CMD_LOAD  = 4'd1;
  localparam logic [3:0] CACHE_CMD_STORE = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd0;
  localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd1;
  localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
  localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd4;
  localparam logic [2:0] LOAD_TYPE_LW = 3'b010;
  typedef enum logic {PORT_FETCH = 1'b0, PORT_EXEC = 1'b1} port_e;
  function automatic logic cache_resp_final(input logic [3:0] r);
    return r inside {CACHE_RESPONSE_DONE, CACHE_RESPONSE_MISSALIGNED,
                     CACHE_RESPONSE_ACCESSFAULT, CACHE_RESPONSE_PAGEFAULT};
  endfunction
endpackage

// File: rtl/corevx_cache_arbiter_if.sv
// corevx_cache_arbiter_if: fetch, execute and shared cache buses around the arbiter
interface corevx_cache_arbiter_if;
  logic [3:0]  f_cmd;
  logic [31:0] f_address;
  logic [3:0]  f_response;
  logic [31:0] f_load_data;
  logic        f_reset_done;
  logic [3:0]  e_cmd;
  logic [31:0] e_address;
  logic [2:0]  e_load_type;
  logic [1:0]  e_store_type;
  logic [31:0] e_store_data;
  logic [3:0]  e_response;
  logic [31:0] e_load_data;
  logic        e_reset_done;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [2:0]  c_load_type;
  logic [1:0]  c_store_type;
  logic [31:0] c_store_data;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        c_reset_done;
  modport slave (
    input  f_cmd, f_address, e_cmd, e_address, e_load_type, e_store_type, e_store_data,
           c_response, c_load_data, c_reset_done,
    output f_response, f_load_data, f_reset_done, e_response, e_load_data, e_reset_done,
           c_cmd, c_address, c_load_type, c_store_type, c_store_data
  );
  modport master (
    output f_cmd, f_address, e_cmd, e_address, e_load_type, e_store_type, e_store_data,
           c_response, c_load_data, c_reset_done,
    input  f_response, f_load_data, f_reset_done, e_response, e_load_data, e_reset_done,
           c_cmd, c_address, c_load_type, c_store_type, c_store_data
  );
endinterface

// File: rtl/corevx_arb2_rr.sv
// corevx_arb2_rr: two-way pick; ties go to the port not granted last, or to port 1 in fixed mode
module corevx_arb2_rr (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_mode,
  output logic [1:0] gnt
);
  assign gnt = &req ? ((fixed_mode || !last) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/corevx_cache_arbiter.sv
// corevx_cache_arbiter: shares one cache port between fetch and execute, one transaction at a time
module corevx_cache_arbiter
  import corevx_cache_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  corevx_cache_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e     state_q, state_d;
  port_e      owner_q, owner_d, last_q, last_d, sel;
  logic [1:0] req, gnt;
  logic       issue, active, exec_sel;
  assign req = {bus.e_cmd != CACHE_CMD_NONE, bus.f_cmd != CACHE_CMD_NONE};
  corevx_arb2_rr u_pick (
    .req       (req),
    .last      (last_q == PORT_EXEC),
    .fixed_mode(!ROUND_ROBIN),
    .gnt       (gnt)
  );
  // rst_n gates issue so a held request cannot leak onto c_cmd while reset is asserted
  assign issue    = rst_n && state_q == IDLE && bus.c_reset_done && |req;
  assign active   = issue || state_q == BUSY;
  assign sel      = state_q == BUSY ? owner_q : (gnt[1] ? PORT_EXEC : PORT_FETCH);
  assign exec_sel = active && sel == PORT_EXEC;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (issue) begin
      state_d = BUSY;
      owner_d = sel;
    end else if (state_q == BUSY && cache_resp_final(bus.c_response)) begin
      state_d = IDLE;
      last_d  = owner_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= PORT_FETCH;
      last_q  <= PORT_FETCH;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  assign bus.c_cmd        = issue ? (exec_sel ? bus.e_cmd : bus.f_cmd) : CACHE_CMD_NONE;
  assign bus.c_address    = !active ? 32'd0 : exec_sel ? bus.e_address : bus.f_address;
  assign bus.c_load_type  = !active ? 3'd0 : exec_sel ? bus.e_load_type : LOAD_TYPE_LW;
  assign bus.c_store_type = exec_sel ? bus.e_store_type : 2'd0;
  assign bus.c_store_data = exec_sel ? bus.e_store_data : 32'd0;
  assign bus.f_response   = state_q == BUSY && owner_q == PORT_FETCH ? bus.c_response : CACHE_RESPONSE_WAIT;
  assign bus.e_response   = state_q == BUSY && owner_q == PORT_EXEC ? bus.c_response : CACHE_RESPONSE_WAIT;
  assign bus.f_load_data  = state_q == BUSY && owner_q == PORT_FETCH ? bus.c_load_data : 32'd0;
  assign bus.e_load_data  = state_q == BUSY && owner_q == PORT_EXEC ? bus.c_load_data : 32'd0;
  assign bus.f_reset_done = bus.c_reset_done;
  assign bus.e_reset_done = bus.c_reset_done;
endmodule

// File: doc/corevx_cache_arbiter.md
COREVX_CACHE_ARBITER -- requirements
Module: corevx_cache_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = alternate winner on simultaneous requests, 0 = execute port always wins.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports f_cmd (input, 4) and f_address (input, 32): fetch-side command and address.
REQ-005 SHALL have ports f_response (output, 4) and f_load_data (output, 32): fetch-side response and read data.
REQ-006 SHALL have ports e_cmd (input, 4), e_address (input, 32), e_load_type (input, 3), e_store_type (input, 2) and e_store_data (input, 32): execute-side request.
REQ-007 SHALL have ports e_response (output, 4) and e_load_data (output, 32): execute-side response and read data.
REQ-008 SHALL have ports c_cmd (output, 4), c_address (output, 32), c_load_type (output, 3), c_store_type (output, 2) and c_store_data (output, 32): shared cache request.
REQ-009 SHALL have ports c_response (input, 4), c_load_data (input, 32) and c_reset_done (input, 1): shared cache response.
REQ-010 SHALL have ports f_reset_done and e_reset_done (outputs, 1 each), driven as direct copies of c_reset_done.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY, plus registers owner (0 = fetch, 1 = execute) and last_grant.
REQ-012 In IDLE with c_reset_done = 1 and at least one requester cmd != CACHE_CMD_NONE, SHALL choose a winner combinationally in the same cycle.
REQ-013 In that IDLE cycle SHALL forward the winner's cmd, address and execute-only fields to c_* (zero-cycle issue), latch owner and go to BUSY.
REQ-014 Winner selection, single requester: that requester wins.
REQ-015 Winner selection, both requesting with ROUND_ROBIN = 1: the port other than last_grant wins.
REQ-016 Winner selection, both requesting with ROUND_ROBIN = 0: execute wins.
REQ-017 In BUSY SHALL drive c_cmd = CACHE_CMD_NONE and keep c_address, c_load_type, c_store_type and c_store_data muxed from owner.
REQ-018 In BUSY SHALL route c_response and c_load_data to owner's port; the non-owner sees CACHE_RESPONSE_WAIT and zero data.
REQ-019 In BUSY, when c_response is DONE, MISSALIGNED, ACCESSFAULT or PAGEFAULT, SHALL return to IDLE next edge and set last_grant = owner; any other response keeps BUSY.
REQ-020 New grants SHALL occur only from IDLE; minimum spacing between two cache commands is 2 cycles.
REQ-021 When fetch drives cache fields, c_load_type SHALL be LW (3'b010), c_store_type 0 and c_store_data 0.
REQ-022 In IDLE without a grant SHALL drive c_cmd = NONE, all other c_* = 0, and both responses WAIT.
REQ-023 While c_reset_done = 0 SHALL issue no grant, stay IDLE, and present WAIT on both ports.
REQ-024 If c_reset_done falls during BUSY, SHALL remain BUSY until a terminating response arrives.
REQ-025 SHALL ignore the non-owner's request during BUSY and not latch it; the requester holds cmd until served.
REQ-026 SHALL ignore changes to the owner's cmd during BUSY.

Reset
REQ-027 On rst_n = 0 SHALL asynchronously force state = IDLE, owner = 0 and last_grant = 0 (fetch), so execute wins the first tie.
REQ-028 During reset, outputs SHALL be c_cmd = NONE, c_* = 0, f_response = e_response = WAIT and load data = 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no response delivered; deassertion SHALL restart in IDLE.

Structure
REQ-030 CACHE_CMD_* and CACHE_RESPONSE_* codes, including CACHE_RESPONSE_WAIT, SHALL come from the shared cache package/header and not be redefined locally.
REQ-031 The arbiter state enum (IDLE, BUSY) SHALL be local to the module.
REQ-032 The winner-select logic SHALL be one sub-module, corevx_arb2_rr (2-way round-robin priority pick), with inputs req[1:0], last and fixed_mode, and output gnt.
REQ-033 The datapath muxing SHALL stay in the top module.

Verification
REQ-034 Fetch only: f_cmd = LOAD, f_address = 0x100 -> c_cmd = LOAD in the same cycle, then NONE; DONE with c_load_data = 0xDEADBEEF after 3 cycles -> f_response = DONE, f_load_data = 0xDEADBEEF, e_response = WAIT.
REQ-035 Tie after reset: both request LOAD -> execute granted first; after DONE, fetch granted 1 idle cycle later; a third tie goes to execute.
REQ-036 ROUND_ROBIN = 0: continuous ties for 4 transactions -> execute always wins and fetch sees WAIT throughout.
REQ-037 Store error: e_cmd = STORE, e_address = 0x3, c_response = MISSALIGNED -> e_response = MISSALIGNED, FSM returns to IDLE, last_grant = execute.
REQ-038 c_reset_done = 0 with both requesting for 5 cycles -> c_cmd stays NONE; first grant occurs in the cycle c_reset_done rises.
REQ-039 rst_n pulsed low mid-BUSY -> c_cmd = NONE and both responses WAIT immediately (asynchronously); after release, a pending fetch request is granted in the first cycle.
